ad7606_seq_ctrl: RTL
====================

Name: ad7606_seq_ctrl

Overview:
Sequencer for the AD7606 8-channel ADC datapath.
- Applies the AD7606 power-on reset pulse, then issues CONVST A/B at a fixed sample rate.
- Tracks BUSY, then reads all channels over the parallel bus with cs_n/rd_n strobes.
- Presents each 16-bit result as a one-cycle ch_valid beat to downstream logic (threshold/key logic, UART framer).

Parameters:
SAMPLE_DIV, 2500, clk_50 cycles between conversion starts (20 kHz at 50 MHz); minimum 200
CH_NUM, 8, channels read per frame (1..8)
RST_CYC, 10, cycles rst_ad7606 is held high after controller reset
CONV_LOW, 2, cycles cva/cvb are held low per conversion start
RD_LOW, 3, cycles rd_n is low per channel; data is captured on the last low cycle
RD_HIGH, 2, cycles rd_n is high between channels
BUSY_TMO, 500, cycles allowed for BUSY rise plus fall (timeout feature only)

Ports:
clk_50  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
run  in  1  1 = sample continuously; 0 = stop after the current frame
os_cfg  in  3  oversampling ratio request
os  out  3  oversampling pins to the ADC
rst_ad7606  out  1  ADC reset
cva  out  1  CONVST A
cvb  out  1  CONVST B
cs_n  out  1  ADC chip select
rd_n  out  1  ADC read strobe
busy  in  1  ADC BUSY (asynchronous; 2-flop synchronised internally)
data  in  16  ADC parallel data
ch_data  out  16  captured channel result
ch_idx  out  3  channel number of ch_data (0..CH_NUM-1)
ch_valid  out  1  one-cycle strobe; ch_data/ch_idx valid
frame_done  out  1  one-cycle strobe after the last channel of a frame
overrun  out  1  one-cycle strobe when a sample tick arrives while a frame is in progress
tmo_err  out  1  one-cycle strobe on BUSY timeout (timeout feature only; otherwise tied 0)

Behaviour:
Reset values:
- rst_ad7606=1, cva=cvb=1, cs_n=1, rd_n=1.
- os=0, ch_data=0, ch_idx=0, all strobes 0.
- State RESET, all counters 0.

Registering and inputs:
- All outputs are registered.
- busy is used only after 2-flop synchronisation (busy_s). Edges are detected on busy_s.

Sample tick counter:
- Counts 0..SAMPLE_DIV-1 and wraps; tick fires at the wrap.
- Runs only while run=1. Cleared while run=0.

State machine:
- RESET: hold rst_ad7606=1 for RST_CYC cycles, then drive 0 and go to IDLE.
- IDLE: latch os <= os_cfg (os changes only here). On tick with run=1, go to CONV.
- CONV: cva=cvb=0 for CONV_LOW cycles, then 1. Go to WAIT_BH.
- WAIT_BH: wait for busy_s rising edge, then go to WAIT_BL.
- WAIT_BL: wait for busy_s falling edge. Then cs_n=0, ch_idx counter=0, go to RD_L.
- RD_L: rd_n=0 for RD_LOW cycles. On the last cycle, ch_data<=data, ch_idx<=counter, and ch_valid pulses the following cycle. Go to RD_H.
- RD_H: rd_n=1 for RD_HIGH cycles.
  - If counter==CH_NUM-1: cs_n=1, frame_done=1 for one cycle, go to IDLE.
  - Otherwise: counter+1, go to RD_L.

Boundary conditions:
- Tick in any state other than IDLE: overrun pulses and the tick is discarded. Ticks are never queued.
- run falling mid-frame: the frame completes normally; the next tick is suppressed.
- rst asserted mid-frame: all outputs return to reset values immediately and the sequence restarts from RESET, including the ADC reset pulse.
- Channel counter is 3 bits and never exceeds CH_NUM-1.
- Timing: one full frame takes CONV_LOW + BUSY time + 2 sync cycles + CH_NUM*(RD_LOW+RD_HIGH) cycles, and must fit within SAMPLE_DIV.

Optional Feature:
Macro AD7606_BUSY_TMO_EN.
- Defined:
  - A cycle counter starts on entry to WAIT_BH and runs through WAIT_BL.
  - If it reaches BUSY_TMO: tmo_err pulses one cycle, cva=cvb=cs_n=rd_n=1, and the state goes to RESET. The ADC reset pulse is re-issued.
- Not defined:
  - No counter; WAIT_BH/WAIT_BL wait indefinitely.
  - tmo_err is constant 0.

Test Plan:
1. Reset release -> rst_ad7606 high exactly 10 cycles, then 0; cva/cvb/cs_n/rd_n stay 1 until the first tick.
2. run=1, busy model high 5 cycles after cvb rises, low 80 cycles later, data increments on each rd_n falling edge -> 8 ch_valid beats, ch_idx 0..7, consecutive data values, one frame_done; next cvb falling edge 2500 cycles after the previous one.
3. os_cfg changed mid-frame from 0 to 3 -> os stays 0 until the frame ends, becomes 3 in IDLE.
4. SAMPLE_DIV=200, BUSY held high 300 cycles -> overrun pulses once per discarded tick; no second conversion starts until IDLE.
5. run deasserted during RD_L of channel 2 -> channels 3..7 still read, frame_done once, no further cva/cvb pulses.
6. AD7606_BUSY_TMO_EN defined, busy tied 0 -> tmo_err pulses 500 cycles after WAIT_BH entry, rst_ad7606 re-pulses 10 cycles; undefined -> controller waits in WAIT_BH indefinitely, tmo_err stays 0.

Source files
------------

// File: rtl/ad7606_seq_ctrl.sv
// AD7606 sequencer: ADC reset pulse, periodic CONVST, BUSY tracking and parallel readout.
// Optional BUSY timeout guard enabled by defining AD7606_BUSY_TMO_EN.
module ad7606_seq_ctrl #(
  parameter int SAMPLE_DIV = 2500,
  parameter int CH_NUM     = 8,
  parameter int RST_CYC    = 10,
  parameter int CONV_LOW   = 2,
  parameter int RD_LOW     = 3,
  parameter int RD_HIGH    = 2,
  parameter int BUSY_TMO   = 500
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        run,
  input  logic [2:0]  os_cfg,
  output logic [2:0]  os,
  output logic        rst_ad7606,
  output logic        cva,
  output logic        cvb,
  output logic        cs_n,
  output logic        rd_n,
  input  logic        busy,
  input  logic [15:0] data,
  output logic [15:0] ch_data,
  output logic [2:0]  ch_idx,
  output logic        ch_valid,
  output logic        frame_done,
  output logic        overrun,
  output logic        tmo_err
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One phase counter serves every timed state, so it is sized for the longest phase.
  localparam int CNT_MAX = max_of(max_of(RST_CYC, BUSY_TMO),
                                  max_of(CONV_LOW, max_of(RD_LOW, RD_HIGH)));
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int TW = $clog2(SAMPLE_DIV);

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_LOW - 1);
  localparam logic [CW-1:0] RDL_LAST  = CW'(RD_LOW - 1);
  localparam logic [CW-1:0] RDH_LAST  = CW'(RD_HIGH - 1);
  localparam logic [2:0]    CH_LAST   = 3'(CH_NUM - 1);

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_CONV, S_WAIT_BH, S_WAIT_BL, S_RD_L, S_RD_H
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      ch_cnt, ch_cnt_n;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic            busy_m, busy_s, busy_d;
  logic            busy_rise, busy_fall;
  logic            capture, done_n;

  // BUSY is asynchronous to clk_50: two flops, then a third for edge detection.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
      busy_d <= 1'b0;
    end else begin
      busy_m <= busy;
      busy_s <= busy_m;
      busy_d <= busy_s;
    end
  end

  assign busy_rise = busy_s & ~busy_d;
  assign busy_fall = ~busy_s & busy_d;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst)
      tick_cnt <= '0;
    else if (!run || tick_cnt == TICK_LAST)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + TW'(1);
  end

  assign tick = run && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state  <= S_RESET;
      cnt    <= '0;
      ch_cnt <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ch_cnt <= ch_cnt_n;
    end
  end

`ifdef AD7606_BUSY_TMO_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TMO - 1);
  logic tmo_n;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ch_cnt_n = ch_cnt;
    capture  = 1'b0;
    done_n   = 1'b0;
`ifdef AD7606_BUSY_TMO_EN
    tmo_n    = 1'b0;
`endif
    case (state)
      S_RESET: begin
        if (cnt == RST_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_IDLE: begin
        if (tick) begin
          state_n = S_CONV;
          cnt_n   = '0;
        end
      end
      S_CONV: begin
        if (cnt == CONV_LAST) begin
          state_n = S_WAIT_BH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_WAIT_BH: begin
        if (busy_rise) state_n = S_WAIT_BL;
      end
      S_WAIT_BL: begin
        if (busy_fall) begin
          state_n  = S_RD_L;
          cnt_n    = '0;
          ch_cnt_n = '0;
        end
      end
      S_RD_L: begin
        if (cnt == RDL_LAST) begin
          capture = 1'b1;
          state_n = S_RD_H;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RD_H: begin
        if (cnt == RDH_LAST) begin
          cnt_n = '0;
          if (ch_cnt == CH_LAST) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            ch_cnt_n = ch_cnt + 3'd1;
            state_n  = S_RD_L;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = S_RESET;
        cnt_n   = '0;
      end
    endcase
`ifdef AD7606_BUSY_TMO_EN
    // The wait counter spans both BUSY edges; a BUSY fall hands over to the read phase.
    if (state == S_WAIT_BH || (state == S_WAIT_BL && !busy_fall)) begin
      if (cnt == TMO_LAST) begin
        tmo_n   = 1'b1;
        state_n = S_RESET;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
`endif
  end

  // Bus strobes are decoded from the next state so they line up exactly with the state register.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      rst_ad7606 <= 1'b1;
      cva        <= 1'b1;
      cvb        <= 1'b1;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      os         <= 3'd0;
      ch_data    <= 16'd0;
      ch_idx     <= 3'd0;
      ch_valid   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rst_ad7606 <= (state_n == S_RESET);
      cva        <= (state_n != S_CONV);
      cvb        <= (state_n != S_CONV);
      cs_n       <= !(state_n == S_RD_L || state_n == S_RD_H);
      rd_n       <= (state_n != S_RD_L);
      if (state == S_IDLE) os <= os_cfg;
      if (capture) begin
        ch_data <= data;
        ch_idx  <= ch_cnt;
      end
      ch_valid   <= capture;
      frame_done <= done_n;
      overrun    <= tick && (state != S_IDLE);
    end
  end

`ifdef AD7606_BUSY_TMO_EN
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) tmo_err <= 1'b0;
    else     tmo_err <= tmo_n;
  end
`else
  assign tmo_err = 1'b0;
`endif

endmodule
